// File: rtl/carbon_uart_tx.sv
// carbon_uart_tx: console transmitter fed by the MMIO UART byte stream.
// Bytes land in a small FIFO and are serialised LSB first on txd at
// CLK_DIV clocks per bit. Default framing is 8N1. Defining the macro
// CARBON_UART_TX_PARITY_EN inserts an even-parity bit, giving 8E1 framing.
// Source pulses are never stalled: a byte offered while full is dropped
// and latches the sticky overflow flag.
`timescale 1ns/1ps

module carbon_uart_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  input  logic                          ovf_clr,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLK_DIV - 1);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("carbon_uart_tx: CLK_DIV must be >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("carbon_uart_tx: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef CARBON_UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q;

  // Serialiser state
  state_t        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic          txd_q;
`ifdef CARBON_UART_TX_PARITY_EN
  logic          parity_q;
`endif

  logic       push, drop, pop, can_pop;
  logic [7:0] head;

  assign in_ready = (count_q != CW'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  assign drop     = in_valid && !in_ready;
  assign can_pop  = (count_q != '0);
  // The head leaves the FIFO when a frame starts: from IDLE, or straight
  // out of the last stop-bit cycle so consecutive frames abut.
  assign pop      = can_pop &&
                    ((state_q == S_IDLE) || (state_q == S_STOP && baud_q == '0));
  assign head     = mem[rd_ptr_q];

  // Occupancy next-state: simultaneous push and pop leave it unchanged.
  always_comb begin
    // NOTE: assign a default first so no path leaves count_d unassigned,
    // which would otherwise infer a latch.
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO data array write.
  // NOTE: the array has no reset; stale entries are unreachable once the
  // pointers and count are cleared, and omitting reset keeps it plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

  // FIFO pointers, occupancy and sticky overflow (set beats clear).
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (drop)         overflow_q <= 1'b1;
      else if (ovf_clr) overflow_q <= 1'b0;
    end
  end

  // Frame sequencer: every bit holds for CLK_DIV cycles; txd is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      txd_q    <= 1'b1;
`ifdef CARBON_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          txd_q <= 1'b1;
          if (pop) begin
            sh_q     <= head;
`ifdef CARBON_UART_TX_PARITY_EN
            parity_q <= ^head;
`endif
            txd_q    <= 1'b0;
            baud_q   <= BAUD_RELOAD;
            state_q  <= S_START;
          end
        end
        S_START: begin
          if (baud_q == '0) begin
            txd_q   <= sh_q[0];
            sh_q    <= {1'b0, sh_q[7:1]};
            bit_q   <= 3'd7;
            baud_q  <= BAUD_RELOAD;
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        S_DATA: begin
          if (baud_q == '0) begin
            baud_q <= BAUD_RELOAD;
            if (bit_q != 3'd0) begin
              txd_q <= sh_q[0];
              sh_q  <= {1'b0, sh_q[7:1]};
              bit_q <= bit_q - 3'd1;
            end else begin
`ifdef CARBON_UART_TX_PARITY_EN
              txd_q   <= parity_q;
              state_q <= S_PARITY;
`else
              txd_q   <= 1'b1;
              state_q <= S_STOP;
`endif
            end
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
`ifdef CARBON_UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_q == '0) begin
            txd_q   <= 1'b1;
            baud_q  <= BAUD_RELOAD;
            state_q <= S_STOP;
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
`endif
        S_STOP: begin
          if (baud_q == '0) begin
            if (pop) begin
              sh_q     <= head;
`ifdef CARBON_UART_TX_PARITY_EN
              parity_q <= ^head;
`endif
              txd_q    <= 1'b0;
              baud_q   <= BAUD_RELOAD;
              state_q  <= S_START;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        default: begin
          txd_q   <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign txd        = txd_q;
  assign busy       = (state_q != S_IDLE) || can_pop;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_carbon_uart_tx.sv
// Scoreboard bench for carbon_uart_tx (CLK_DIV=4, FIFO_DEPTH=8).
// Stimulus queues expected bytes; a UART receiver process decodes txd and
// checks each frame bit-by-bit against the queued byte.
`timescale 1ns/1ps

module tb_carbon_uart_tx;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 8;
`ifdef CARBON_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       ovf_clr = 1'b0;
  logic       in_ready, txd, busy, overflow;
  logic [$clog2(DEPTH):0] fifo_count;

  carbon_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .ovf_clr    (ovf_clr),
    .txd        (txd),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_q[$];
  int unsigned start_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Receiver: on the first low sample of an idle line, pop the expected
  // byte, then compare every cycle of the frame against the model bits.
  int                    rx_pos = -1;
  int                    rx_glitch = 0;
  logic [7:0]            rx_exp = 8'h00;
  logic [7:0]            rx_byte = 8'h00;
  logic [FRAME_BITS-1:0] rx_bits = '1;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_pos = -1;
    end else begin
      if (rx_pos < 0 && txd === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
          rx_exp = 8'h00;
        end else begin
          rx_exp = exp_q.pop_front();
        end
        rx_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) rx_bits[i+1] = rx_exp[i];
`ifdef CARBON_UART_TX_PARITY_EN
        rx_bits[9] = ^rx_exp;
`endif
        rx_bits[FRAME_BITS-1] = 1'b1;
        rx_pos    = 0;
        rx_glitch = 0;
        rx_byte   = 8'h00;
        start_q.push_back(cyc);
      end
      if (rx_pos >= 0) begin
        if (txd !== rx_bits[rx_pos / CLK_DIV]) rx_glitch++;
        if ((rx_pos % CLK_DIV) == CLK_DIV / 2 &&
            (rx_pos / CLK_DIV) >= 1 && (rx_pos / CLK_DIV) <= 8)
          rx_byte[rx_pos / CLK_DIV - 1] = txd;
        rx_pos++;
        if (rx_pos == FRAME_CYC) begin
          check("frame_byte", rx_byte, rx_exp);
          check("frame_bit_errors", rx_glitch, 0);
          rx_pos = -1;
        end
      end
    end
  end

  task automatic wait_idle(input int max_cyc, input string name);
    int n = 0;
    while (busy === 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  task automatic check_gaps(input int base, input int nframes, input string name);
    check({name, "_frames"}, start_q.size() - base, nframes);
    for (int i = 1; i < nframes; i++) begin
      if (base + i < start_q.size())
        check({name, "_gap"}, start_q[base+i] - start_q[base+i-1], FRAME_CYC);
    end
  endtask

  initial begin
    int base;
    int n;
    int lows;
    logic [7:0] t5_bytes [4];
    logic [7:0] t2_bytes [3];
    t5_bytes = '{8'h3C, 8'hC3, 8'h5A, 8'hA5};
    t2_bytes = '{8'h01, 8'h80, 8'hFF};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single byte latency, bit timing, busy duration
    exp_q.push_back(8'h55);
    in_data = 8'h55; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("t1_count_after_push", fifo_count, 1);
    check("t1_txd_before_pop", txd, 1'b1);
    check("t1_busy_after_push", busy, 1'b1);
    @(negedge clk);
    check("t1_txd_fall", txd, 1'b0);
    check("t1_count_after_pop", fifo_count, 0);
    repeat (39) @(negedge clk);
    check("t1_busy_last_cycle", busy, 1'b1);
    @(negedge clk);
    check("t1_busy_fall", busy, 1'b0);
    check("t1_scoreboard_empty", exp_q.size(), 0);

    // 2: back-to-back frames
    repeat (3) @(negedge clk);
    base = start_q.size();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(t2_bytes[i]);
      in_data = t2_bytes[i]; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_idle(4 * FRAME_CYC, "t2_drain");
    check_gaps(base, 3, "t2");
    check("t2_overflow", overflow, 1'b0);
    check("t2_scoreboard_empty", exp_q.size(), 0);

    // 3: fill past full while one frame is in flight
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      in_data = 8'(i); in_valid = 1'b1;
      if (i == 8) check("t3_ready_before_full", in_ready, 1'b1);
      if (i == 9) check("t3_ready_full", in_ready, 1'b0);
      else exp_q.push_back(8'(i));
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("t3_overflow", overflow, 1'b1);
    check("t3_count_full", fifo_count, DEPTH);

    // 4: drop and clear together -> set wins; clear alone -> cleared
    check("t4_still_full", in_ready, 1'b0);
    in_data = 8'hAA; in_valid = 1'b1; ovf_clr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("t4_set_wins", overflow, 1'b1);
    check("t4_count", fifo_count, DEPTH);
    @(negedge clk);
    ovf_clr = 1'b0;
    check("t4_cleared", overflow, 1'b0);
    wait_idle(10 * FRAME_CYC + 100, "t3_drain");
    check("t3_scoreboard_empty", exp_q.size(), 0);

    // 5: asynchronous reset mid-frame discards everything
    repeat (3) @(negedge clk);
    base = start_q.size();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(t5_bytes[i]);
      in_data = t5_bytes[i]; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n = 0;
    while (start_q.size() == base && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t5_frame_started", start_q.size() > base, 1'b1);
    // Start sample is cycle 0; data bit 3 spans frame cycles 16..19.
    n = 0;
    while (start_q.size() > base && (cyc - start_q[base]) < 17 && n < 50) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    #1;
    check("t5_rst_txd", txd, 1'b1);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_count", fifo_count, 0);
    check("t5_rst_in_ready", in_ready, 1'b1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    check("t5_no_residual_bits", lows, 0);
    check("t5_idle_busy", busy, 1'b0);

`ifdef CARBON_UART_TX_PARITY_EN
    // 6: 8E1 framing, parity 1 for 0x07 and 0 for 0x03
    repeat (3) @(negedge clk);
    base = start_q.size();
    exp_q.push_back(8'h07);
    exp_q.push_back(8'h03);
    in_data = 8'h07; in_valid = 1'b1;
    @(negedge clk);
    in_data = 8'h03;
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle(3 * FRAME_CYC, "t6_drain");
    check_gaps(base, 2, "t6");
    check("t6_scoreboard_empty", exp_q.size(), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/carbon_uart_tx.md
Name: carbon_uart_tx

Overview:
- Downstream consumer of the MMIO register block's UART transmit byte stream (uart_tx_valid / uart_tx_byte).
- Buffers bytes in a small FIFO and serialises them onto a single asynchronous TX line: 8N1, LSB first, fixed integer clock divider.
- Gives the CarbonZ380 and sibling systems a real console output instead of unconnected UART ports.
- Status outputs (busy, fill level, sticky overflow) let the testbench and system glue know when the console has drained before poweroff.

Parameters:
- CLK_DIV, 16: clk cycles per serial bit. Must be >= 2; elaboration error otherwise.
- FIFO_DEPTH, 8: FIFO entries. Must be a power of two, >= 2; elaboration error otherwise.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  byte offered this cycle (may be a single-cycle pulse with no backpressure honoured by the source).
- in_data  input  8  byte to transmit.
- in_ready  output  1  FIFO not full.
- ovf_clr  input  1  clears overflow.
- txd  output  1  serial line; idle high.
- busy  output  1  FIFO non-empty or frame in progress.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH.
- overflow  output  1  sticky; a byte was dropped.

Behaviour:
- Reset values (asynchronous, takes effect immediately, including mid-frame): txd=1, busy=0, in_ready=1, fifo_count=0, overflow=0, state IDLE. FIFO contents are discarded.
- FIFO write and drop:
  - in_ready = (fifo_count != FIFO_DEPTH), derived from registered count.
  - Push on in_valid && in_ready.
  - in_valid && !in_ready: byte dropped, overflow <= 1.
- Overflow clear: ovf_clr clears overflow. If a drop and ovf_clr occur in the same cycle, set wins (overflow=1).
- Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally.
- Occupancy arithmetic:
  - Push and pop in the same cycle: count unchanged.
  - Push when full is impossible (in_ready=0).
  - Pop only when count>0.
- State machine:
  - IDLE: txd=1. At an edge where count>0, pop the head into shift register, txd<=0, baud_cnt<=CLK_DIV-1, go to START.
  - START: when baud_cnt==0, txd<=sh[0], shift right, bit_cnt<=7, baud_cnt reload, go to DATA. Otherwise decrement baud_cnt.
  - DATA: when baud_cnt==0, if bit_cnt!=0 emit next bit and decrement bit_cnt; if bit_cnt==0, txd<=1 and go to STOP.
  - STOP: when baud_cnt==0:
    - count>0: pop, txd<=0, go to START. Back-to-back frames, zero idle cycles.
    - otherwise go to IDLE.
- Bit and frame timing:
  - Every bit (start, 8 data, stop) holds exactly CLK_DIV cycles.
  - Frame = 10*CLK_DIV cycles.
- Latency: push into an empty FIFO while IDLE, then txd falls 2 clk edges after the push edge (push edge, then IDLE pop edge).
- busy = (state != IDLE) || (count != 0), registered-equivalent. It falls on the same edge the state enters IDLE with count 0.
- txd is driven from a flop (glitch-free).

Optional Feature:
- Macro CARBON_UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - Transmits the even-parity bit (XOR of the 8 data bits) for CLK_DIV cycles.
  - Frame = 11*CLK_DIV cycles (8E1).
- Undefined: no PARITY state; 8N1, 10*CLK_DIV-cycle frames.

Test Plan:
1. CLK_DIV=4, single push of 0x55 into an idle block -> txd falls 2 edges after the push. Then txd holds each of 0,1,0,1,0,1,0,1,0,1 for 4 cycles. busy drops 40 cycles after txd falls. fifo_count returns to 0 one edge after the push is popped.
2. CLK_DIV=4, pushes of 0x01, 0x80, 0xFF on consecutive cycles -> three contiguous 40-cycle frames with no idle high between the stop bit and the next start bit. Data LSB first. overflow stays 0.
3. FIFO_DEPTH=8, in_valid held for 10 consecutive cycles with bytes 0x00..0x09 -> in_ready=0 on the 10th cycle. Byte 0x09 is dropped, overflow=1, fifo_count=8. Bytes 0x00..0x08 are transmitted in order.
4. Overflow set, then ovf_clr pulsed in the same cycle as a further dropped push -> overflow stays 1. ovf_clr alone on the next cycle -> overflow=0.
5. Assert rst_n low during DATA bit 3 of a frame with 4 bytes queued -> txd=1, busy=0, fifo_count=0 immediately. After release, no residual bytes are transmitted.
6. Built with CARBON_UART_TX_PARITY_EN, CLK_DIV=4, byte 0x07 -> parity bit 1 held for 4 cycles before the stop bit. Frame = 44 cycles. Byte 0x03 -> parity bit 0.
